stream_burst_reader: RTL and testbench

STREAM_BURST_READER -- requirements
Module: stream_burst_reader

---
 rtl/stream_burst_pkg.sv | 21 ++
 rtl/axis_out_reg.sv | 31 +++
 rtl/stream_burst_reader.sv | 129 ++++++++++++
 tb/tb_stream_burst_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_burst_pkg.sv
// Shared constants for the burst-framing stream reader: default parameters,
// FSM state encoding and the idle-timer width helper.
package stream_burst_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_COUNT_W   = 11;
    localparam int unsigned DEF_BURST_LEN = 16;
    localparam int unsigned DEF_TIMEOUT   = 1024;

    // State encoding (plain constants for compatibility with older tools)
    localparam int unsigned STATE_W  = 2;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_BURST = 2'd1;
    localparam logic [1:0]  ST_FLUSH = 2'd2;

    // Bits needed to hold 0..timeout; never less than one bit
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry valid/ready output register: one cycle of latency, full
// throughput, payload held stable while the consumer stalls.
module axis_out_reg #(
    parameter int unsigned PAYLOAD_W = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [PAYLOAD_W-1:0] s_payload,
    output logic                 s_ready_c,
    output logic                 m_valid,
    output logic [PAYLOAD_W-1:0] m_payload,
    input  logic                 m_ready
);

    // Accept whenever the slot is empty or is being drained this cycle
    assign s_ready_c = !m_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_payload <= '0;
        end else if (s_valid && s_ready_c) begin
            m_valid   <= 1'b1;
            m_payload <= s_payload;
        end else if (m_ready) begin
            m_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_burst_reader.sv
// Drains an upstream FIFO in fixed-length bursts framed with TLAST, flushing
// a partial fill after a programmable idle timeout.
module stream_burst_reader
    import stream_burst_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned COUNT_W   = DEF_COUNT_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COUNT_W-1:0] count,
    input  logic [WIDTH-1:0]   in0_V_V_TDATA,
    input  logic               in0_V_V_TVALID,
    output logic               in0_V_V_TREADY,
    output logic [WIDTH-1:0]   out_V_V_TDATA,
    output logic               out_V_V_TVALID,
    output logic               out_V_V_TLAST,
    input  logic               out_V_V_TREADY,
    output logic               busy,
    output logic [15:0]        burst_cnt,
    output logic [15:0]        flush_cnt
);

    localparam int unsigned        TIMER_W     = timer_width(TIMEOUT);
    localparam logic [COUNT_W-1:0] BURST_LEN_C = COUNT_W'(BURST_LEN);
    localparam logic [TIMER_W-1:0] TIMEOUT_C   = TIMER_W'(TIMEOUT);

    logic [STATE_W-1:0] state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [15:0]        burst_cnt_q, flush_cnt_q;

    logic               reg_s_ready_c;
    logic               reg_m_valid;
    logic [WIDTH:0]     reg_m_payload;
    logic               in_hs;
    logic               out_last_hs;

    assign in0_V_V_TREADY = (state_q != ST_IDLE) && (remaining_q != '0) && reg_s_ready_c;
    assign in_hs          = in0_V_V_TVALID && in0_V_V_TREADY;
    assign out_last_hs    = reg_m_valid && out_V_V_TREADY && reg_m_payload[WIDTH];

    // Next-state, remaining and idle-timer logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (count >= BURST_LEN_C) begin
                    state_d     = ST_BURST;
                    remaining_d = BURST_LEN_C;
                    timer_d     = '0;
                end else if (count == '0) begin
                    timer_d = '0;
                end else if ((TIMEOUT != 0) && (timer_q == TIMEOUT_C)) begin
                    state_d     = ST_FLUSH;
                    remaining_d = count;
                    timer_d     = '0;
                end else if (timer_q != TIMEOUT_C) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_BURST, ST_FLUSH: begin
                if (in_hs) begin
                    remaining_d = remaining_q - COUNT_W'(1);
                end
                // Leave only once the framed last word has been taken downstream
                if (out_last_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
                timer_d     = '0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
        end
    end

    // Completed-burst and completed-flush statistics, wrapping at 16 bits
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            burst_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (out_last_hs) begin
            if (state_q == ST_BURST) begin
                burst_cnt_q <= burst_cnt_q + 16'd1;
            end else if (state_q == ST_FLUSH) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    axis_out_reg #(
        .PAYLOAD_W (WIDTH + 1)
    ) u_out_reg (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .s_valid   (in_hs),
        .s_payload ({(remaining_q == COUNT_W'(1)), in0_V_V_TDATA}),
        .s_ready_c (reg_s_ready_c),
        .m_valid   (reg_m_valid),
        .m_payload (reg_m_payload),
        .m_ready   (out_V_V_TREADY)
    );

    assign out_V_V_TVALID = reg_m_valid;
    assign out_V_V_TDATA  = reg_m_payload[WIDTH-1:0];
    assign out_V_V_TLAST  = reg_m_payload[WIDTH];
    assign busy           = (state_q != ST_IDLE) || reg_m_valid;
    assign burst_cnt      = burst_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_stream_burst_reader.sv
// Directed bench for stream_burst_reader: full bursts, timeout flush, output
// stalls, back-to-back bursts, mid-burst reset and a disabled-timeout instance.
module tb_stream_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] count;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic [15:0] burst_cnt;
    logic [15:0] flush_cnt;

    logic        rst0_n;
    logic [10:0] count0;
    logic        in_ready0;
    logic [31:0] out_data0;
    logic        out_valid0;
    logic        out_last0;
    logic        busy0;
    logic [15:0] burst_cnt0;
    logic [15:0] flush_cnt0;

    int checks = 0;
    int errors = 0;

    int unsigned level     = 0;
    int unsigned next_word = 0;
    int unsigned cyc       = 0;
    bit          toggle    = 0;
    int          stab_err  = 0;
    int          rdy_err   = 0;
    int          busy_falls = 0;
    int          act0      = 0;

    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [31:0] p_data  = '0;
    logic        p_last  = 1'b0;
    logic        p_busy  = 1'b0;

    logic [32:0] out_q[$];
    int unsigned out_cyc[$];

    always #5 clk = ~clk;

    stream_burst_reader #(
        .WIDTH(32), .COUNT_W(11), .BURST_LEN(16), .TIMEOUT(8)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .count(count),
        .in0_V_V_TDATA(in_data), .in0_V_V_TVALID(in_valid), .in0_V_V_TREADY(in_ready),
        .out_V_V_TDATA(out_data), .out_V_V_TVALID(out_valid), .out_V_V_TLAST(out_last),
        .out_V_V_TREADY(out_ready), .busy(busy), .burst_cnt(burst_cnt), .flush_cnt(flush_cnt)
    );

    stream_burst_reader #(
        .WIDTH(32), .COUNT_W(11), .BURST_LEN(16), .TIMEOUT(0)
    ) dut0 (
        .ap_clk(clk), .ap_rst_n(rst0_n), .count(count0),
        .in0_V_V_TDATA(in_data), .in0_V_V_TVALID(1'b1), .in0_V_V_TREADY(in_ready0),
        .out_V_V_TDATA(out_data0), .out_V_V_TVALID(out_valid0), .out_V_V_TLAST(out_last0),
        .out_V_V_TREADY(1'b1), .busy(busy0), .burst_cnt(burst_cnt0), .flush_cnt(flush_cnt0)
    );

    always @(negedge clk) begin
        if (rst0_n && (out_valid0 || busy0 || in_ready0)) act0++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int unsigned k);
        return 32'hA000_0000 + 32'(k);
    endfunction

    task automatic set_level(input int unsigned n);
        level = n;
        count = 11'(n);
    endtask

    // One clock: sample at the falling edge, then update the FIFO model after the rising edge
    task automatic step();
        logic in_hs;
        logic out_hs;
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        if (rst_n && p_valid && !p_ready) begin
            if (!out_valid || out_data !== p_data || out_last !== p_last) stab_err++;
        end
        if (out_valid && !out_ready && in_ready) rdy_err++;
        if (out_hs) begin
            out_q.push_back({out_last, out_data});
            out_cyc.push_back(cyc);
        end
        if (p_busy && !busy) busy_falls++;
        p_valid = out_valid;
        p_ready = out_ready;
        p_data  = out_data;
        p_last  = out_last;
        p_busy  = busy;
        @(posedge clk);
        #1;
        cyc++;
        if (in_hs) begin
            level--;
            next_word++;
        end
        count   = 11'(level);
        in_data = word(next_word);
        if (toggle) out_ready = ~out_ready;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_words(input string tag, input int exp_n, input int unsigned first,
                               input int l1, input int l2, input int l3);
        int bad_d;
        int bad_l;
        logic exp_last;
        bad_d = 0;
        bad_l = 0;
        check({tag, "_words"}, 64'(out_q.size()), 64'(exp_n));
        for (int i = 0; i < out_q.size(); i++) begin
            exp_last = (i == l1 - 1) || (i == l2 - 1) || (i == l3 - 1);
            if (out_q[i][31:0] !== word(first + 32'(i))) bad_d++;
            if (out_q[i][32] !== exp_last) bad_l++;
        end
        check({tag, "_data"}, 64'(bad_d), 64'd0);
        check({tag, "_last"}, 64'(bad_l), 64'd0);
    endtask

    initial begin
        int unsigned first;
        int n;
        rst_n     = 1'b0;
        rst0_n    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        count0    = 11'd3;
        set_level(0);
        in_data   = word(0);
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        rst_n  = 1'b1;
        rst0_n = 1'b1;
        run(3);

        // Full burst with free-flowing streams
        first = next_word;
        out_q.delete();
        out_cyc.delete();
        set_level(16);
        run(30);
        check_words("full", 16, first, 16, -1, -1);
        if (out_cyc.size() == 16) check("full_back_to_back", 64'(out_cyc[15] - out_cyc[0]), 64'd15);
        else check("full_cycle_log", 64'(out_cyc.size()), 64'd16);
        check("full_burst_cnt", 64'(burst_cnt), 64'd1);
        check("full_flush_cnt", 64'(flush_cnt), 64'd0);

        // Partial fill flushed after the idle timeout
        first = next_word;
        out_q.delete();
        set_level(5);
        n = 0;
        while (!busy && n < 40) begin
            n++;
            step();
        end
        check("flush_idle_samples", 64'(n), 64'd9);
        run(20);
        check_words("flush", 5, first, 5, -1, -1);
        check("flush_flush_cnt", 64'(flush_cnt), 64'd1);
        check("flush_burst_cnt", 64'(burst_cnt), 64'd1);

        // Downstream ready toggling every cycle
        first = next_word;
        out_q.delete();
        stab_err = 0;
        rdy_err  = 0;
        toggle   = 1;
        set_level(16);
        run(60);
        toggle    = 0;
        out_ready = 1'b1;
        check_words("stall", 16, first, 16, -1, -1);
        check("stall_stable", 64'(stab_err), 64'd0);
        check("stall_in_ready", 64'(rdy_err), 64'd0);
        check("stall_burst_cnt", 64'(burst_cnt), 64'd2);

        // 40 words: two bursts then an 8-word timeout flush
        run(2);
        first = next_word;
        out_q.delete();
        busy_falls = 0;
        set_level(40);
        run(120);
        check_words("two_bursts", 40, first, 16, 32, 40);
        check("two_bursts_idle_gaps", 64'(busy_falls), 64'd3);
        check("two_bursts_burst_cnt", 64'(burst_cnt), 64'd4);
        check("two_bursts_flush_cnt", 64'(flush_cnt), 64'd2);

        // Reset asserted in the middle of a burst
        out_q.delete();
        set_level(16);
        n = 0;
        while (out_q.size() < 7 && n < 40) begin
            n++;
            step();
        end
        check("mid_rst_words_before", 64'(out_q.size()), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_last", 64'(out_last), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_burst_cnt", 64'(burst_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        p_valid = 1'b0;
        p_busy  = 1'b0;
        first   = next_word;
        out_q.delete();
        set_level(16);
        rst_n = 1'b1;
        run(30);
        check_words("post_rst", 16, first, 16, -1, -1);
        check("post_rst_burst_cnt", 64'(burst_cnt), 64'd1);
        check("post_rst_flush_cnt", 64'(flush_cnt), 64'd0);

        // Let the timeout-disabled instance sit on count=3 for well over 5000 cycles
        run(5000);
        check("no_timeout_activity", 64'(act0), 64'd0);
        check("no_timeout_flush_cnt", 64'(flush_cnt0), 64'd0);
        check("no_timeout_burst_cnt", 64'(burst_cnt0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
